// File: rtl/bus_master_seq.sv
// -----------------------------------------------------------------------------
// bus_master_seq
//
// Master (initiator) for the 8-bit asynchronous host bus. It has a 16-bit
// address, an 8-bit bidirectional data bus and active-low RD_B/WR_B strobes.
// It turns user-side burst commands into timed strobe cycles:
// SETUP_CYCLES, then STROBE_CYCLES with the strobe low, then HOLD_CYCLES.
// Write beats pass through a LOAD state that waits for write data.
//
// Compile-time option:
//   BUS_MASTER_ADDR_INC_EN  defined   : the address advances by 1 per beat
//                                       (it wraps from 16'hFFFF to 16'h0000)
//                           undefined : the address stays fixed for the whole
//                                       burst (FIFO-port access)
//
// Ports:
//   bus_clk, bus_rst_b   clock; asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; cmd_ready is high only in IDLE
//   cmd_write            1 = write burst, 0 = read burst
//   cmd_add              burst start address
//   cmd_len              beat count (0 means 256)
//   wdata/wdata_valid/wdata_ready   write beat stream
//   rdata/rdata_valid/rdata_ready   read beat stream; a beat is held until
//                                   it is consumed
//   rdata_last           marks the final beat of a read burst
//   done                 one-cycle pulse after the final HOLD cycle
//   add, data_out        bus address and bus write data
//   data_oe              drive enable for the DATA pad
//   data_in              bus read data from the pad
//   rd_b, wr_b           registered bus strobes, active-low
// -----------------------------------------------------------------------------
module bus_master_seq #(
   parameter int SETUP_CYCLES  = 1,
   parameter int STROBE_CYCLES = 2,
   parameter int HOLD_CYCLES   = 1
) (
   input  logic        bus_clk,
   input  logic        bus_rst_b,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [15:0] cmd_add,
   input  logic [7:0]  cmd_len,
   input  logic [7:0]  wdata,
   input  logic        wdata_valid,
   output logic        wdata_ready,
   output logic [7:0]  rdata,
   output logic        rdata_valid,
   input  logic        rdata_ready,
   output logic        rdata_last,
   output logic        done,
   output logic [15:0] add,
   output logic [7:0]  data_out,
   output logic        data_oe,
   input  logic [7:0]  data_in,
   output logic        rd_b,
   output logic        wr_b
);

   localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYCLES - 1);
   localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYCLES - 1);
   localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD
   } state_t;

   state_t      state_reg,       state_next;
   logic [7:0]  cnt_reg,         cnt_next;
   logic [8:0]  beats_reg,       beats_next;
   logic        write_reg,       write_next;
   logic [15:0] add_reg,         add_next;
   logic [7:0]  data_out_reg,    data_out_next;
   logic        data_oe_reg,     data_oe_next;
   logic [7:0]  rdata_reg,       rdata_next;
   logic        rdata_valid_reg, rdata_valid_next;
   logic        rdata_last_reg,  rdata_last_next;
   logic        done_reg,        done_next;
   logic        rd_b_reg,        rd_b_next;
   logic        wr_b_reg,        wr_b_next;
   // Keeps cmd_ready low until the first clock edge after reset is released.
   logic        started_reg;

   assign cmd_ready   = started_reg && (state_reg == ST_IDLE);
   assign wdata_ready = (state_reg == ST_LOAD);

   assign rdata       = rdata_reg;
   assign rdata_valid = rdata_valid_reg;
   assign rdata_last  = rdata_last_reg;
   assign done        = done_reg;
   assign add         = add_reg;
   assign data_out    = data_out_reg;
   assign data_oe     = data_oe_reg;
   assign rd_b        = rd_b_reg;
   assign wr_b        = wr_b_reg;

   always_ff @(posedge bus_clk or negedge bus_rst_b) begin
      if (!bus_rst_b) begin
         state_reg       <= ST_IDLE;
         cnt_reg         <= '0;
         beats_reg       <= '0;
         write_reg       <= 1'b0;
         add_reg         <= '0;
         data_out_reg    <= '0;
         data_oe_reg     <= 1'b0;
         rdata_reg       <= '0;
         rdata_valid_reg <= 1'b0;
         rdata_last_reg  <= 1'b0;
         done_reg        <= 1'b0;
         rd_b_reg        <= 1'b1;
         wr_b_reg        <= 1'b1;
         started_reg     <= 1'b0;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         beats_reg       <= beats_next;
         write_reg       <= write_next;
         add_reg         <= add_next;
         data_out_reg    <= data_out_next;
         data_oe_reg     <= data_oe_next;
         rdata_reg       <= rdata_next;
         rdata_valid_reg <= rdata_valid_next;
         rdata_last_reg  <= rdata_last_next;
         done_reg        <= done_next;
         rd_b_reg        <= rd_b_next;
         wr_b_reg        <= wr_b_next;
         started_reg     <= 1'b1;
      end
   end

   always_comb begin
      state_next       = state_reg;
      cnt_next         = cnt_reg;
      beats_next       = beats_reg;
      write_next       = write_reg;
      add_next         = add_reg;
      data_out_next    = data_out_reg;
      data_oe_next     = data_oe_reg;
      rdata_next       = rdata_reg;
      rdata_last_next  = rdata_last_reg;
      done_next        = 1'b0;
      // A pending read beat is retired by the consumer at any time,
      // including while the master sits in IDLE.
      rdata_valid_next = rdata_valid_reg && !rdata_ready;

      case (state_reg)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               write_next = cmd_write;
               add_next   = cmd_add;
               beats_next = (cmd_len == 8'd0) ? 9'd256 : {1'b0, cmd_len};
               cnt_next   = '0;
               state_next = cmd_write ? ST_LOAD : ST_SETUP;
            end
         end

         ST_LOAD: begin
            if (wdata_valid) begin
               data_out_next = wdata;
               data_oe_next  = 1'b1;
               cnt_next      = '0;
               state_next    = ST_SETUP;
            end
         end

         ST_SETUP: begin
            // A read does not start its strobe while the previous beat is
            // still unconsumed, so that beat is never overwritten.
            if (write_reg || !rdata_valid_reg) begin
               if (cnt_reg == SETUP_LAST) begin
                  cnt_next   = '0;
                  state_next = ST_STROBE;
               end else begin
                  cnt_next = 8'(cnt_reg + 8'd1);
               end
            end
         end

         ST_STROBE: begin
            if (cnt_reg == STROBE_LAST) begin
               cnt_next   = '0;
               state_next = ST_HOLD;
               if (!write_reg) begin
                  // Capture on the last low cycle; valid rises with HOLD.
                  rdata_next       = data_in;
                  rdata_valid_next = 1'b1;
                  rdata_last_next  = (beats_reg == 9'd1);
               end
            end else begin
               cnt_next = 8'(cnt_reg + 8'd1);
            end
         end

         ST_HOLD: begin
            if (cnt_reg == HOLD_LAST) begin
               cnt_next   = '0;
               beats_next = 9'(beats_reg - 9'd1);
               if (beats_reg == 9'd1) begin
                  done_next    = 1'b1;
                  data_oe_next = 1'b0;
                  state_next   = ST_IDLE;
               end else begin
`ifdef BUS_MASTER_ADDR_INC_EN
                  add_next = 16'(add_reg + 16'd1);
`else
                  add_next = add_reg;
`endif
                  state_next = write_reg ? ST_LOAD : ST_SETUP;
               end
            end else begin
               cnt_next = 8'(cnt_reg + 8'd1);
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // Strobes are registered from the next state. Only one of them can be
      // low, and it is low exactly while the FSM is in STROBE.
      rd_b_next = !((state_next == ST_STROBE) && !write_reg);
      wr_b_next = !((state_next == ST_STROBE) &&  write_reg);
   end

endmodule
